md_pad_emu: RTL
===============

Name: md_pad_emu

Overview:
- Device-side emulator of the Megadrive DB9 splitter plus two Megadrive pads, each 3- or 6-button.
- Responds to the select line (joy_mdsel) and split line (joy_split) driven by the host pad reader. Drives the shared 6-bit active-low data bus from two internal button vectors.
- Used for loopback self-test of the reader, and to present MiSTer joystick state to an external Megadrive-style host.

Parameters:
- TIMEOUT, 8192, clk cycles with no select falling edge before the 6-button phase counter returns to idle (host state period is 256 clk; must exceed 2 states and be below 200 states).
- SYNC_STAGES, 2, synchroniser depth for joy_mdsel and joy_split (legal 2..3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- joy_mdsel  in  1  select from host; async, synchronised internally
- joy_split  in  1  splitter port select from host: 0 = pad 1, 1 = pad 2; async, synchronised internally
- joystick1  in  12  pad 1 buttons, active-high, [11:0] = M Z Y X S C B A U D L R
- joystick2  in  12  pad 2 buttons, same format
- pad_6btn  in  2  per-pad 6-button enable: bit0 = pad 1, bit1 = pad 2
- joy_out  out  6  active-low data bus to host, bit order [5:0]
- phase  out  3  current low-phase count 0..4 (debug)

Behaviour:
- Reset: joy_out = 6'h3F, phase = 0, timeout timer = 0, synchroniser flops = 1.
- Synchronisation: sel_s and split_s are the SYNC_STAGES-deep flop outputs. Falling edge fall = sel_s_d & ~sel_s.
- Phase counter (shared by both pads), evaluated in priority order each cycle:
  - timer reaching TIMEOUT-1 sets phase to 0.
  - fall sets phase to 1 if phase was 0 or the timer expired this cycle; otherwise phase = min(phase+1, 4), saturating at 4.
  - Timer clears on fall, increments otherwise, and saturates at TIMEOUT-1.
- Data select: pad p = split_s ? 2 : 1. J = that pad's vector. E = pad_6btn of p.
- Raw (active-high) data, chosen by sel_s, phase and E:
  - sel_s=1 and (phase != 3 or !E): {C,B,U,D,L,R}
  - sel_s=1 and phase == 3 and E: {C,B,Z,Y,X,M}
  - sel_s=0 and phase in {0,1,2}, or !E: {S,A,U,D,0,0}. The two low bits are forced pressed, which marks the device as a Megadrive pad.
  - sel_s=0, phase == 3, E: {S,A,0,0,0,0}. This marks 6-button.
  - sel_s=0, phase == 4, E: {S,A,1,1,1,1}
- Forced-0 bits are emitted pre-inversion as 1, so they read low on the bus.
- Output: joy_out <= ~raw, registered.
- Latency: a pin edge on joy_mdsel or joy_split reaches joy_out in SYNC_STAGES+1 clk (3 at default). A button change reaches joy_out in 1 clk.
- Phase is decoded from the same-cycle updated phase value, so the low-phase data and the phase increment are coherent.
- Split toggles mid-phase: only the mux changes; the phase counter is unaffected.
- pad_6btn changing mid-sequence takes effect the next cycle; no glitch beyond one registered update.
- Reset asserted mid-sequence: immediate return to reset values on the next clk. The first host read after release sees a 3-button-compatible idle pad.
- Loopback contract: the host reader's 12-bit output equals the emulated pad's input vector (6-button pad), or {0000, J[7:0]} (3-button pad).

Test Plan:
- Reset, joy_mdsel=1, split=0, joystick1=12'h000 -> joy_out=6'h3F, phase=0; 3 clk after sel falls -> joy_out=6'h3C (L/R low), phase=1.
- Pad 1 6-button, joystick1=12'h801 (M,R), sel sequence L,H,L,H,L (256-clk states) -> on 3rd low joy_out=6'h30; following high joy_out=6'h3E (M low); 4th low joy_out=6'h3F.
- Same as previous with pad_6btn=0 -> 3rd low joy_out=6'h3C, following high joy_out=6'h3E (R low), phase still counts to 3.
- Stop toggling sel for TIMEOUT clk -> phase=0; next fall -> phase=1, not 5. Fall coincident with expiry -> phase=1.
- Split alternating every 32 clk, joystick1=12'hA5A, joystick2=12'h5A5, both 6-button, host reader instantiated in loopback -> reader joystick1=12'hA5A, joystick2=12'h5A5 after one full 256-state frame.
- Assert reset during phase 3 -> next clk joy_out=6'h3F, phase=0; 6 more low phases -> phase saturates at 4, joy_out low data = {S,A,1,1,1,1} inverted.

Source files
------------

// File: rtl/md_pad_emu.sv
// Megadrive DB9 splitter plus two pads, device side.
// The host drives select (joy_mdsel) and the splitter port (joy_split).
// The emulator answers on a 6-bit active-low bus from two 12-bit button
// vectors, each laid out as [11:0] = M Z Y X S C B A U D L R.
// A 6-button pad reports its extra buttons on the third low/high select pair.
module md_pad_emu #(
   parameter int TIMEOUT     = 8192,  // idle clk cycles before the low-phase count returns to idle
   parameter int SYNC_STAGES = 2      // synchroniser depth for the host lines (2..3)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        joy_mdsel,
   input  logic        joy_split,
   input  logic [11:0] joystick1,
   input  logic [11:0] joystick2,
   input  logic [1:0]  pad_6btn,
   output logic [5:0]  joy_out,
   output logic [2:0]  phase
);

   // Timer width holds TIMEOUT-1, the saturation value.
   localparam int              TW        = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT - 1);

   // Low-phase count: idle, then one state per select falling edge,
   // saturating at the fourth low phase.
   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_1    = 3'd1,
      PH_2    = 3'd2,
      PH_3    = 3'd3,
      PH_4    = 3'd4
   } phase_t;

   phase_t                   state_reg;
   phase_t                   state_next;
   logic [TW-1:0]            timer_reg;
   logic [TW-1:0]            timer_next;

   logic [SYNC_STAGES-1:0]   sel_sync_reg;
   logic [SYNC_STAGES-1:0]   split_sync_reg;
   logic                     sel_s;
   logic                     split_s;
   logic                     sel_s_d_reg;
   logic                     fall;
   logic                     expire;

   logic [11:0]              pad_vec [2];
   logic [5:0]               raw_sel;
   logic [5:0]               joy_out_reg;

   // ------------------------------------------------------------------
   // Host line synchronisers. Flops idle high so that reset looks like an
   // idle host with select high and no edge pending.
   // ------------------------------------------------------------------

   // Shift the asynchronous select and split pins through the sync chains.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_sync_reg   <= '1;
         split_sync_reg <= '1;
         sel_s_d_reg    <= 1'b1;
      end else begin
         sel_sync_reg   <= {sel_sync_reg[SYNC_STAGES-2:0], joy_mdsel};
         split_sync_reg <= {split_sync_reg[SYNC_STAGES-2:0], joy_split};
         sel_s_d_reg    <= sel_s;
      end
   end

   assign sel_s   = sel_sync_reg[SYNC_STAGES-1];
   assign split_s = split_sync_reg[SYNC_STAGES-1];
   assign fall    = sel_s_d_reg & ~sel_s;
   assign expire  = (timer_reg == TIMER_MAX);

   // ------------------------------------------------------------------
   // Phase counter and idle timer, shared by both pads so that the split
   // line only steers the data mux and never disturbs the sequence.
   // ------------------------------------------------------------------

   // Register the phase state and the idle timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= PH_IDLE;
         timer_reg <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
      end
   end

   // Next phase: a falling edge advances (or restarts from idle / after an
   // expiry in the same cycle); an expired timer alone drops back to idle.
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      if (fall) begin
         timer_next = '0;
         if (state_reg == PH_IDLE || expire) begin
            state_next = PH_1;
         end else begin
            case (state_reg)
               PH_1:    state_next = PH_2;
               PH_2:    state_next = PH_3;
               default: state_next = PH_4;
            endcase
         end
      end else begin
         if (expire) begin
            state_next = PH_IDLE;
         end else begin
            timer_next = timer_reg + 1'b1;
         end
      end
   end

   assign phase = state_reg;

   // ------------------------------------------------------------------
   // Per-pad data decode. Raw values are active-high; bits the protocol
   // forces low on the bus are 1 here and flip low at the output.
   // The updated phase is used so the data matches the edge just taken.
   // ------------------------------------------------------------------

   assign pad_vec[0] = joystick1;
   assign pad_vec[1] = joystick2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_pad
         logic [11:0] j;
         logic        six;
         logic [5:0]  raw;

         assign j   = pad_vec[gi];
         assign six = pad_6btn[gi];

         // Choose this pad's raw nibble from select level, phase and mode.
         always_comb begin
            raw = 6'b000000;
            if (sel_s) begin
               if (state_next == PH_3 && six) begin
                  raw = {j[6], j[5], j[10], j[9], j[8], j[11]};   // C B Z Y X M
               end else begin
                  raw = {j[6], j[5], j[3], j[2], j[1], j[0]};     // C B U D L R
               end
            end else begin
               if (!six || state_next == PH_IDLE || state_next == PH_1 ||
                   state_next == PH_2) begin
                  raw = {j[7], j[4], j[3], j[2], 2'b11};          // S A U D, pad id low
               end else if (state_next == PH_3) begin
                  raw = {j[7], j[4], 4'b1111};                    // 6-button id, all low
               end else begin
                  raw = {j[7], j[4], 4'b0000};                    // S A, rest released
               end
            end
         end
      end
   endgenerate

   assign raw_sel = split_s ? g_pad[1].raw : g_pad[0].raw;

   // Register the inverted data onto the active-low bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         joy_out_reg <= 6'h3F;
      end else begin
         joy_out_reg <= ~raw_sel;
      end
   end

   assign joy_out = joy_out_reg;

endmodule
